// File: rtl/drm_fifo_pkg.sv
// Shared constants and helpers for the drm_8x64-backed show-ahead FIFO controller.
package drm_fifo_pkg;

    localparam int unsigned FIFO_ADDR_WIDTH   = 6;
    localparam int unsigned FIFO_DATA_WIDTH   = 8;
    localparam int unsigned FIFO_DEPTH        = 2 ** FIFO_ADDR_WIDTH;
    localparam int unsigned FIFO_OBUF_DEPTH   = 2;
    localparam int unsigned FIFO_AFULL_THRESH = 56;

    typedef logic [1:0] obuf_cnt_t;

    // True when a read issued now still has a buffer slot by the time its data lands.
    function automatic logic obuf_has_room(obuf_cnt_t buf_cnt, logic inflight, logic pop);
        logic [2:0] occ;
        occ = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
        return occ < 3'(FIFO_OBUF_DEPTH);
    endfunction

endpackage

// File: rtl/drm_fifo_obuf.sv
// Two-entry output buffer that absorbs the RAM read latency; head entry is the FIFO output.
module drm_fifo_obuf
    import drm_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic [1:0]            buf_cnt,
    output logic [1:0]            buf_cnt_next
);

    logic [DATA_WIDTH-1:0] slot_q [FIFO_OBUF_DEPTH];
    logic                  head_q, head_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  wr_idx;
    logic                  pop_ok;
    logic                  push_ok;

    always_comb begin
        pop_ok  = pop && (cnt_q != 2'd0);
        push_ok = push && ((cnt_q != 2'd2) || pop_ok);
        // With two slots the free slot is always head xor occupancy.
        wr_idx  = head_q ^ cnt_q[0];
        head_d  = head_q ^ pop_ok;
        cnt_d   = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            slot_q[wr_idx] <= push_data;
        end
    end

    assign out_data     = slot_q[head_q];
    assign out_valid    = (cnt_q != 2'd0);
    assign buf_cnt      = cnt_q;
    assign buf_cnt_next = cnt_d;

endmodule

// File: rtl/drm_fifo_ctrl.sv
// Show-ahead FIFO controller: owns drm_8x64 pointers, issues reads and feeds a 2-entry output buffer.
module drm_fifo_ctrl
    import drm_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = FIFO_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = FIFO_DATA_WIDTH,
    parameter int unsigned AFULL_THRESH = FIFO_AFULL_THRESH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic                  ram_wr_en,
    output logic                  ram_wr_byte_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam int unsigned         DEPTH     = 2 ** ADDR_WIDTH;
    localparam int unsigned         CNT_MAX   = DEPTH + FIFO_OBUF_DEPTH;
    localparam logic [ADDR_WIDTH+1:0] CNT_MAX_W = (ADDR_WIDTH + 2)'(CNT_MAX);
    localparam logic [ADDR_WIDTH:0]   AFULL_LVL = (ADDR_WIDTH + 1)'(AFULL_THRESH);

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  afull_q, afull_d;
    logic [ADDR_WIDTH+1:0] total_d;
    logic [1:0]            buf_cnt, buf_cnt_d;
    logic                  ram_empty, ram_full;
    logic                  wr_en, pop, issue;

    always_comb begin
        ram_empty  = (wr_ptr_q == rd_ptr_q);
        ram_full   = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                     (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
        in_ready   = !ram_full && !rst;
        wr_en      = in_valid && in_ready;
        pop        = out_valid && out_ready;
        // Reads come from registered pointers only, so a read never targets the slot being written.
        issue      = !ram_empty && obuf_has_room(buf_cnt, inflight_q, pop);
        wr_ptr_d   = wr_ptr_q + (ADDR_WIDTH + 1)'(wr_en);
        rd_ptr_d   = rd_ptr_q + (ADDR_WIDTH + 1)'(issue);
        inflight_d = issue;
    end

    // Count tracks the post-edge occupancy so it lines up with in_ready and out_valid.
    always_comb begin
        ram_cnt_d = wr_ptr_d - rd_ptr_d;
        total_d   = {1'b0, ram_cnt_d} + (ADDR_WIDTH + 2)'(inflight_d) +
                    (ADDR_WIDTH + 2)'(buf_cnt_d);
        count_d   = (total_d > CNT_MAX_W) ? CNT_MAX_W[ADDR_WIDTH:0] : total_d[ADDR_WIDTH:0];
        afull_d   = (count_d >= AFULL_LVL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            afull_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            afull_q    <= afull_d;
        end
    end

    drm_fifo_obuf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_obuf (
        .clk         (clk),
        .rst         (rst),
        .push        (inflight_q),
        .push_data   (ram_rd_data),
        .pop         (pop),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .buf_cnt     (buf_cnt),
        .buf_cnt_next(buf_cnt_d)
    );

    assign count          = count_q;
    assign almost_full    = afull_q;
    assign ram_wr_data    = in_data;
    assign ram_wr_addr    = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_wr_en      = wr_en;
    assign ram_wr_byte_en = 1'b1;
    assign ram_rd_addr    = rd_ptr_q[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_drm_fifo_ctrl.sv
// Directed bench for drm_fifo_ctrl with a behavioural 64x8 one-cycle-read RAM and a scoreboard.
module tb_drm_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] count;
    logic       almost_full;
    logic [7:0] ram_wr_data;
    logic [5:0] ram_wr_addr;
    logic       ram_wr_en;
    logic       ram_wr_byte_en;
    logic [5:0] ram_rd_addr;
    logic [7:0] ram_rd_data;

    logic [7:0] mem [64];
    logic [7:0] sb_q [$];
    int         n_checks;
    int         n_fail;
    int         pop_cnt;
    logic       stall_prev;
    logic [7:0] held;

    drm_fifo_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .count         (count),
        .almost_full   (almost_full),
        .ram_wr_data   (ram_wr_data),
        .ram_wr_addr   (ram_wr_addr),
        .ram_wr_en     (ram_wr_en),
        .ram_wr_byte_en(ram_wr_byte_en),
        .ram_rd_addr   (ram_rd_addr),
        .ram_rd_data   (ram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Scoreboard work happens on the values about to be sampled, then one clock passes.
    task automatic step();
        if (rst) begin
            sb_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) sb_q.push_back(in_data);
            if (ram_wr_en && count >= 7'd4)
                check_val("rw_addr_differ", 32'(ram_rd_addr != ram_wr_addr), 32'd1);
            if (stall_prev && out_valid) check_val("out_hold", 32'(out_data), 32'(held));
            if (out_valid && out_ready) begin
                pop_cnt++;
                if (sb_q.size() == 0) check_val("pop_no_data", 32'(out_data), 32'hFFFF_FFFF);
                else check_val("out_order", 32'(out_data), 32'(sb_q.pop_front()));
            end
            stall_prev = out_valid && !out_ready;
            held       = out_data;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard     = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((out_valid || count != 7'd0) && guard < 300) begin
            step();
            guard++;
        end
        out_ready = 1'b0;
        check_val({tag, "_count"}, 32'(count), 32'd0);
        check_val({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int  next;
        int  af_at;
        int  p0;
        int  n_acc;
        int  guard;
        logic acc;

        n_checks   = 0;
        n_fail     = 0;
        pop_cnt    = 0;
        stall_prev = 1'b0;
        held       = 8'h00;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        out_ready  = 1'b0;
        @(negedge clk);
        repeat (3) step();

        // Reset state
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_afull", 32'(almost_full), 32'd0);
        check_val("byte_en", 32'(ram_wr_byte_en), 32'd1);
        rst = 1'b0;
        #1;
        check_val("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Single byte latency
        in_valid = 1'b1;
        in_data  = 8'h11;
        step();
        in_valid = 1'b0;
        check_val("lat_e1_valid", 32'(out_valid), 32'd0);
        check_val("lat_e1_count", 32'(count), 32'd1);
        step();
        check_val("lat_e2_valid", 32'(out_valid), 32'd0);
        step();
        check_val("lat_e3_valid", 32'(out_valid), 32'd1);
        check_val("lat_e3_data", 32'(out_data), 32'h11);
        check_val("lat_e3_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val("lat_pop_valid", 32'(out_valid), 32'd0);
        check_val("lat_pop_count", 32'(count), 32'd0);

        // Fill with no consumer: 64 in RAM plus 2 in the buffer
        next     = 0;
        af_at    = -1;
        in_valid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            in_data = 8'(next);
            if (almost_full && af_at < 0) af_at = int'(count);
            acc = in_ready;
            step();
            if (acc) next++;
        end
        check_val("fill_accepted", 32'(next), 32'd66);
        check_val("fill_count", 32'(count), 32'd66);
        check_val("fill_in_ready", 32'(in_ready), 32'd0);
        check_val("fill_afull", 32'(almost_full), 32'd1);
        check_val("afull_first_at", 32'(af_at), 32'd56);
        check_val("fill_head", 32'(out_data), 32'h00);

        // Pop from full: one slot frees, then a write and a capture refill it
        in_data   = 8'(next);
        out_ready = 1'b1;
        check_val("full_wr_en", 32'(ram_wr_en), 32'd0);
        step();
        check_val("full_pop_count", 32'(count), 32'd65);
        check_val("full_pop_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        acc = in_ready;
        step();
        if (acc) next++;
        check_val("refill_count", 32'(count), 32'd66);
        check_val("refill_ready", 32'(in_ready), 32'd0);
        in_data = 8'(next);
        check_val("refill_wr_en", 32'(ram_wr_en), 32'd0);
        step();
        check_val("hold_full_count", 32'(count), 32'd66);
        check_val("hold_full_ready", 32'(in_ready), 32'd0);
        drain("drain_full");

        // Streaming at 1 byte/cycle, 200 bytes crosses the pointer wrap
        p0        = pop_cnt;
        n_acc     = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            in_data = 8'(i * 7 + 3);
            if (in_ready) n_acc++;
            step();
        end
        check_val("stream_accepted", 32'(n_acc), 32'd200);
        check_val("stream_pops", 32'(pop_cnt - p0), 32'd197);
        check_val("stream_count", 32'(count), 32'd3);
        drain("drain_stream");

        // Random backpressure, 1000 bytes
        n_acc = 0;
        guard = 0;
        while (n_acc < 1000 && guard < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            in_data   = 8'($urandom);
            acc = in_valid && in_ready;
            step();
            if (acc) n_acc++;
            guard++;
        end
        check_val("rand_accepted", 32'(n_acc), 32'd1000);
        drain("drain_rand");

        // Reset mid-flight with a read outstanding
        in_valid = 1'b1;
        for (int i = 0; i < 31; i++) begin
            in_data = 8'(8'hC0 + i);
            step();
        end
        check_val("pre_rst_count31", 32'(count), 32'd31);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check_val("pre_rst_count30", 32'(count), 32'd30);
        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        check_val("mid_rst_in_ready", 32'(in_ready), 32'd0);
        step();
        check_val("mid_rst_valid", 32'(out_valid), 32'd0);
        check_val("mid_rst_count", 32'(count), 32'd0);
        check_val("mid_rst_afull", 32'(almost_full), 32'd0);
        rst = 1'b0;
        #1;
        check_val("post_rst_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        step();
        in_data = 8'h5A;
        step();
        in_valid = 1'b0;
        step();
        check_val("post_rst_valid", 32'(out_valid), 32'd1);
        check_val("post_rst_first", 32'(out_data), 32'hA5);
        check_val("post_rst_count", 32'(count), 32'd2);
        drain("drain_post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
